shift_seq_ctrl: RTL and testbench

Command sequencer that drives the control inputs of the team's universal shift register (univ_shift_reg).
- Accepts one command at a time over a valid/ready handshake: load, shift-left by k, shift-right by k, or rotate-left by k (optional).
- Expands each command into cycle-by-cycle sr_ctrl/sr_d values and signals completion with a one-cycle done pulse.
- Sits directly upstream of the shift register; shares its clock and reset.

---
 rtl/shift_seq_ctrl_pkg.sv | 24 ++
 rtl/shift_seq_ctrl_if.sv | 28 ++
 rtl/shift_seq_ctrl_amt_counter.sv | 39 +++
 rtl/shift_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the shift-register command sequencer: op codes, sr_ctrl
// encodings and FSM states.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROTL = 2'b11
  } op_e;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SHL  = 2'b01;
  localparam logic [1:0] SR_SHR  = 2'b10;
  localparam logic [1:0] SR_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command handshake plus shift-register control bundle; the sequencer uses
// the slave modport, the command source / register side uses master.
interface shift_seq_ctrl_if #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_amt;
  logic             cmd_fill;
  logic [N-1:0]     cmd_data;
  logic [N-1:0]     sr_q;
  logic [1:0]       sr_ctrl;
  logic [N-1:0]     sr_d;
  logic             busy;
  logic             done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_fill, cmd_data, sr_q,
    output cmd_ready, sr_ctrl, sr_d, busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_fill, cmd_data, sr_q,
    input  cmd_ready, sr_ctrl, sr_d, busy, done
  );
endinterface

// File: rtl/shift_seq_ctrl_amt_counter.sv
// Loadable shift-amount down-counter; loads min(amt, N) and flags the final
// shift cycle when the count is 1.
module shift_amt_counter #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] amt_i,
  input  logic             dec_i,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(N);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (amt_i > MAX_AMT) ? MAX_AMT : amt_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer expanding load/shift/rotate commands into per-cycle
// sr_ctrl/sr_d for univ_shift_reg. Define SHIFT_SEQ_ROT_EN to enable ROTL.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  shift_seq_ctrl_if.slave  bus
);

  state_e       state_q, state_d;
  op_e          op_q;
  logic         fill_q;
  logic [N-1:0] data_q;
  logic         accept;
  logic         cnt_last;
  logic [1:0]   ctrl_dec;
  logic [N-1:0] data_dec;

  assign accept = bus.cmd_valid && (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      fill_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op_e'(bus.cmd_op);
        fill_q <= bus.cmd_fill;
        data_q <= bus.cmd_data;
      end
    end
  end

  shift_amt_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_amt_counter (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept),
    .amt_i  (bus.cmd_amt),
    .dec_i  (state_q == ST_SHIFT),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (op_e'(bus.cmd_op))
            OP_LOAD: state_d = ST_LOAD;
            OP_SHL,
            OP_SHR:  state_d = (bus.cmd_amt == '0) ? ST_DONE : ST_SHIFT;
`ifdef SHIFT_SEQ_ROT_EN
            default: state_d = (bus.cmd_amt == '0) ? ST_DONE : ST_SHIFT;
`else
            // Rotate not built: acknowledge the command without touching the register.
            default: state_d = ST_DONE;
`endif
          endcase
        end
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: if (cnt_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state and latched fields only.
  always_comb begin
    ctrl_dec = SR_HOLD;
    data_dec = '0;
    case (state_q)
      ST_LOAD: begin
        ctrl_dec = SR_LOAD;
        data_dec = data_q;
      end
      ST_SHIFT: begin
        case (op_q)
          OP_SHR: begin
            ctrl_dec = SR_SHR;
            data_dec = {N{fill_q}};
          end
`ifdef SHIFT_SEQ_ROT_EN
          OP_ROTL: begin
            ctrl_dec = SR_SHL;
            data_dec = {{(N-1){1'b0}}, bus.sr_q[N-1]};
          end
`endif
          default: begin
            ctrl_dec = SR_SHL;
            data_dec = {N{fill_q}};
          end
        endcase
      end
      default: begin
        ctrl_dec = SR_HOLD;
        data_dec = '0;
      end
    endcase
  end

`ifndef SHIFT_SEQ_ROT_EN
  logic unused_sr_q;
  assign unused_sr_q = ^bus.sr_q;
`endif

  assign bus.sr_ctrl   = ctrl_dec;
  assign bus.sr_d      = data_dec;
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl driving a behavioural
// universal shift register; honours SHIFT_SEQ_ROT_EN.
module tb_shift_seq_ctrl;

  logic clk;
  logic reset;
  logic [7:0] q;
  int n_checks;
  int n_errors;

  shift_seq_ctrl_if #(.N(8)) bus ();

  shift_seq_ctrl #(.N(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register model: 01 left (shift in d[0]), 10 right (shift in d[N-1]), 11 load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 8'h00;
    end else begin
      case (bus.sr_ctrl)
        2'b01:   q <= {q[6:0], bus.sr_d[0]};
        2'b10:   q <= {bus.sr_d[7], q[7:1]};
        2'b11:   q <= bus.sr_d;
        default: q <= q;
      endcase
    end
  end
  assign bus.sr_q = q;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] amt, input logic fill,
                         input logic [7:0] data, output int active, output logic [1:0] ctrl_seen,
                         output logic [7:0] d_seen, output int done_cyc, output logic ready_after);
    active    = 0;
    ctrl_seen = 2'b00;
    d_seen    = 8'h00;
    done_cyc  = -1;
    bus.cmd_op    = op;
    bus.cmd_amt   = amt;
    bus.cmd_fill  = fill;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.sr_ctrl != 2'b00) begin
        active++;
        ctrl_seen = bus.sr_ctrl;
        d_seen    = bus.sr_d;
      end
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ready_after = bus.cmd_ready;
    $display("cmd op=%0d amt=%0d fill=%0b data=%h active=%0d done_cyc=%0d q=%h",
             op, amt, fill, data, active, done_cyc, q);
  endtask

  int         act, dcyc;
  logic [1:0] cs;
  logic [7:0] ds;
  logic       rdy;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_amt   = '0;
    bus.cmd_fill  = 1'b0;
    bus.cmd_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_sr_ctrl", 32'(bus.sr_ctrl), 32'h0);
    check_eq("rst_sr_d", 32'(bus.sr_d), 32'h0);
    check_eq("rst_done", 32'(bus.done), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_ready", 32'(bus.cmd_ready), 32'h1);
    $display("reset state checked");
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: LOAD 0xA5
    run_cmd(2'b00, 4'd0, 1'b0, 8'hA5, act, cs, ds, dcyc, rdy);
    check_eq("t1_active", 32'(act), 32'd1);
    check_eq("t1_ctrl", 32'(cs), 32'h3);
    check_eq("t1_sr_d", 32'(ds), 32'hA5);
    check_eq("t1_done_cyc", 32'(dcyc), 32'd2);
    check_eq("t1_q", 32'(q), 32'hA5);
    check_eq("t1_ready", 32'(rdy), 32'h1);

    // 2: SHL 3 fill 1 -> 0x2F
    run_cmd(2'b01, 4'd3, 1'b1, 8'h00, act, cs, ds, dcyc, rdy);
    check_eq("t2_active", 32'(act), 32'd3);
    check_eq("t2_ctrl", 32'(cs), 32'h1);
    check_eq("t2_sr_d", 32'(ds), 32'hFF);
    check_eq("t2_done_cyc", 32'(dcyc), 32'd4);
    check_eq("t2_q", 32'(q), 32'h2F);

    // 3: SHR amt 0 completes without shifting
    run_cmd(2'b10, 4'd0, 1'b1, 8'h00, act, cs, ds, dcyc, rdy);
    check_eq("t3_active", 32'(act), 32'd0);
    check_eq("t3_done_cyc", 32'(dcyc), 32'd1);
    check_eq("t3_ready", 32'(rdy), 32'h1);
    check_eq("t3_q", 32'(q), 32'h2F);

    // 4: load 0xFF, SHR 12 fill 0 clamps to 8; a held LOAD 0x3C waits for IDLE
    run_cmd(2'b00, 4'd0, 1'b0, 8'hFF, act, cs, ds, dcyc, rdy);
    check_eq("t4_preload_q", 32'(q), 32'hFF);
    begin
      int shr_cnt, first_ready, load_cyc, n_done, early_ready;
      shr_cnt = 0; first_ready = -1; load_cyc = -1; n_done = 0; early_ready = 0;
      bus.cmd_op = 2'b10; bus.cmd_amt = 4'd12; bus.cmd_fill = 1'b0; bus.cmd_data = 8'h00;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_op = 2'b00; bus.cmd_data = 8'h3C;
      for (int c = 1; c <= 14; c++) begin
        if (bus.sr_ctrl == 2'b10) shr_cnt++;
        if (bus.cmd_ready && first_ready < 0) first_ready = c;
        if (bus.cmd_ready && c < 10) early_ready++;
        if (bus.sr_ctrl == 2'b11 && load_cyc < 0) begin
          load_cyc = c;
          bus.cmd_valid = 1'b0;
        end
        if (bus.done) n_done++;
        if (c == 9) check_eq("t4_q_after_shr", 32'(q), 32'h00);
        @(posedge clk); #1;
      end
      bus.cmd_valid = 1'b0;
      $display("t4 shr_cnt=%0d first_ready=%0d load_cyc=%0d n_done=%0d q=%h",
               shr_cnt, first_ready, load_cyc, n_done, q);
      check_eq("t4_shr_cycles", 32'(shr_cnt), 32'd8);
      check_eq("t4_ready_while_busy", 32'(early_ready), 32'd0);
      check_eq("t4_first_ready", 32'(first_ready), 32'd10);
      check_eq("t4_load_cyc", 32'(load_cyc), 32'd11);
      check_eq("t4_done_count", 32'(n_done), 32'd2);
      check_eq("t4_q_final", 32'(q), 32'h3C);
    end

    // 5: reset during 2nd SHL cycle aborts with no done
    begin
      int n_done;
      n_done = 0;
      bus.cmd_op = 2'b01; bus.cmd_amt = 4'd5; bus.cmd_fill = 1'b1; bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("t5_shifting", 32'(bus.sr_ctrl), 32'h1);
      reset = 1'b1;
      #1;
      check_eq("t5_rst_ctrl", 32'(bus.sr_ctrl), 32'h0);
      check_eq("t5_rst_busy", 32'(bus.busy), 32'h0);
      check_eq("t5_rst_ready", 32'(bus.cmd_ready), 32'h1);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (bus.done) n_done++;
        @(posedge clk); #1;
      end
      $display("t5 done pulses after abort=%0d", n_done);
      check_eq("t5_no_done", 32'(n_done), 32'd0);
    end

    // 6: load 0x81, then ROTL 1
    run_cmd(2'b00, 4'd0, 1'b0, 8'h81, act, cs, ds, dcyc, rdy);
    check_eq("t6_preload_q", 32'(q), 32'h81);
    run_cmd(2'b11, 4'd1, 1'b0, 8'h00, act, cs, ds, dcyc, rdy);
`ifdef SHIFT_SEQ_ROT_EN
    check_eq("t6_active", 32'(act), 32'd1);
    check_eq("t6_ctrl", 32'(cs), 32'h1);
    check_eq("t6_done_cyc", 32'(dcyc), 32'd2);
    check_eq("t6_q", 32'(q), 32'h03);
`else
    check_eq("t6_active", 32'(act), 32'd0);
    check_eq("t6_done_cyc", 32'(dcyc), 32'd1);
    check_eq("t6_q", 32'(q), 32'h81);
`endif
    check_eq("t6_ready", 32'(rdy), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
